// File: rtl/fast_pulse_counter_if.sv
// fast_pulse_counter_if: pulse inputs, snapshot/clear controls and snapshot results
interface fast_pulse_counter_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       Fast;
  logic             snap_req;
  logic             clr_req;
  logic [CNT_W-1:0] channel0;
  logic [CNT_W-1:0] channel1;
  logic [CNT_W-1:0] channel2;
  logic [CNT_W-1:0] channel3;
  logic             snap_valid;
  logic [3:0]       overflow;
  modport master (
    output Fast, snap_req, clr_req,
    input  channel0, channel1, channel2, channel3, snap_valid, overflow
  );
  modport slave (
    input  Fast, snap_req, clr_req,
    output channel0, channel1, channel2, channel3, snap_valid, overflow
  );
endinterface

// File: rtl/fast_pulse_counter.sv
// fast_pulse_counter: four synchronized, glitch-filtered rising-edge counters with snapshot and clear
module fast_pulse_counter #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  fast_pulse_counter_if.slave bus
);
  localparam logic [7:0] RUN_MAX = 8'(FILT_LEN - 1);
  logic [3:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]            filt_q, filt_d, filt_prev_q, filt_prev_d, rise;
  logic [3:0][7:0]       run_q, run_d;
  logic [3:0][CNT_W-1:0] live_q, live_d, snap_q, snap_d;
  logic [3:0]            lovf_q, lovf_d, ovf_q, ovf_d;
  logic                  snap_valid_q, snap_valid_d;
  always_comb begin
    sync1_d      = bus.Fast;
    sync2_d      = sync1_q;
    filt_d       = filt_q;
    filt_prev_d  = filt_q;
    rise         = filt_q & ~filt_prev_q;
    run_d        = '0;
    snap_d       = bus.snap_req ? live_q : snap_q;
    ovf_d        = bus.snap_req ? lovf_q : ovf_q;
    snap_valid_d = bus.snap_req;
    lovf_d       = bus.clr_req ? '0 : lovf_q;
    for (int i = 0; i < 4; i++) begin
      // a level is accepted only after FILT_LEN consecutive disagreeing cycles
      if (sync2_q[i] != filt_q[i]) begin
        if (run_q[i] == RUN_MAX) filt_d[i] = sync2_q[i];
        else run_d[i] = run_q[i] + 8'd1;
      end
      live_d[i] = (bus.clr_req ? '0 : live_q[i]) + CNT_W'(rise[i]);
      if (rise[i] && !bus.clr_req && (&live_q[i])) lovf_d[i] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      filt_prev_q  <= '0;
      run_q        <= '0;
      live_q       <= '0;
      snap_q       <= '0;
      lovf_q       <= '0;
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      filt_prev_q  <= filt_prev_d;
      run_q        <= run_d;
      live_q       <= live_d;
      snap_q       <= snap_d;
      lovf_q       <= lovf_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
    end
  end
  assign bus.channel0   = snap_q[0];
  assign bus.channel1   = snap_q[1];
  assign bus.channel2   = snap_q[2];
  assign bus.channel3   = snap_q[3];
  assign bus.overflow   = ovf_q;
  assign bus.snap_valid = snap_valid_q;
endmodule

// File: tb/tb_fast_pulse_counter.sv
// tb_fast_pulse_counter: directed and randomized checks against a pulse-level reference model
module tb_fast_pulse_counter;
  localparam int F = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  fast_pulse_counter_if #(.CNT_W(W)) bus ();
  fast_pulse_counter #(.FILT_LEN(F), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [3:0][W-1:0] dch;
  assign dch = {bus.channel3, bus.channel2, bus.channel1, bus.channel0};
  // model: accepted level per channel, pending counts that land 3 edges after acceptance
  logic [3:0][W-1:0] m_live, m_ch;
  logic [3:0]        m_lovf, m_ovf, m_lvl, p0, p1, p2;
  logic              m_sv;
  int                run [4];
  task automatic tick();
    logic [3:0] inc;
    @(posedge clk);
    if (!rst) begin
      m_live = '0; m_ch = '0; m_lovf = '0; m_ovf = '0; m_lvl = '0;
      p0 = '0; p1 = '0; p2 = '0; m_sv = 1'b0;
      for (int c = 0; c < 4; c++) run[c] = 0;
    end else begin
      inc = p2; p2 = p1; p1 = p0; p0 = '0;
      for (int c = 0; c < 4; c++) begin
        if (bus.Fast[c] != m_lvl[c]) begin
          run[c]++;
          if (run[c] == F) begin
            m_lvl[c] = ~m_lvl[c];
            run[c] = 0;
            p0[c] = m_lvl[c];
          end
        end else run[c] = 0;
      end
      m_sv = bus.snap_req;
      if (bus.snap_req) begin m_ch = m_live; m_ovf = m_lovf; end
      for (int c = 0; c < 4; c++) begin
        if (bus.clr_req) begin m_live[c] = '0; m_lovf[c] = 1'b0; end
        if (inc[c]) begin
          if (m_live[c] == {W{1'b1}}) m_lovf[c] = 1'b1;
          m_live[c] = m_live[c] + W'(1);
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic pulses(input int ch, input int n, input int hi, input int lo);
    repeat (n) begin
      bus.Fast[ch] = 1'b1; repeat (hi) tick();
      bus.Fast[ch] = 1'b0; repeat (lo) tick();
    end
  endtask
  task automatic snap(input logic clr);
    bus.snap_req = 1'b1; bus.clr_req = clr; tick();
    bus.snap_req = 1'b0; bus.clr_req = 1'b0;
  endtask
  task automatic clear();
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0; repeat (3) tick();
  endtask
  task automatic test_reset();
    bus.Fast = '0; bus.snap_req = 1'b0; bus.clr_req = 1'b0; rst = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dch[c] !== '0) begin errors++; $display("FAIL reset_ch%0d: got %0d expected 0", c, dch[c]); end
    end
    checks++;
    if (bus.overflow !== 4'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0000", bus.overflow); end
    checks++;
    if (bus.snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid: got %b expected 0", bus.snap_valid); end
    rst = 1'b1; tick();
  endtask
  task automatic test_pulse_train();
    repeat (10) pulses(0, 1, 8, 8);
    snap(1'b0);
    checks++;
    if (dch[0] !== W'(10)) begin errors++; $display("FAIL train_ch0: got %0d expected 10", dch[0]); end
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (dch[c] !== '0) begin errors++; $display("FAIL train_ch%0d: got %0d expected 0", c, dch[c]); end
    end
    checks++;
    if (bus.snap_valid !== 1'b1) begin errors++; $display("FAIL train_valid: got %b expected 1", bus.snap_valid); end
    tick();
    checks++;
    if (bus.snap_valid !== 1'b0) begin errors++; $display("FAIL train_valid_drop: got %b expected 0", bus.snap_valid); end
    checks++;
    if (dch[0] !== W'(10)) begin errors++; $display("FAIL train_hold: got %0d expected 10", dch[0]); end
  endtask
  task automatic test_glitch();
    clear();
    pulses(2, 3, 3, 5);
    bus.Fast[2] = 1'b1; repeat (9) tick();
    bus.Fast[2] = 1'b0; tick();
    bus.Fast[2] = 1'b1; repeat (10) tick();
    bus.Fast[2] = 1'b0; repeat (10) tick();
    snap(1'b0);
    checks++;
    if (dch[2] !== W'(1)) begin errors++; $display("FAIL glitch_ch2: got %0d expected 1", dch[2]); end
    checks++;
    if (dch[2] !== m_ch[2]) begin errors++; $display("FAIL glitch_model: got %0d expected %0d", dch[2], m_ch[2]); end
  endtask
  task automatic test_latency();
    logic [W-1:0] exp_v [3];
    exp_v = '{W'(0), W'(0), W'(1)};
    clear();
    bus.Fast[1] = 1'b1;
    repeat (F + 1) tick();
    bus.snap_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dch[1] !== exp_v[k]) begin errors++; $display("FAIL latency_edge%0d: got %0d expected %0d", F + 2 + k, dch[1], exp_v[k]); end
      checks++;
      if (bus.snap_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", k, bus.snap_valid); end
    end
    bus.snap_req = 1'b0; tick();
    checks++;
    if (bus.snap_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end: got %b expected 0", bus.snap_valid); end
    bus.Fast[1] = 1'b0; repeat (8) tick();
  endtask
  task automatic test_clr_count();
    clear();
    pulses(0, 3, 8, 8);
    bus.Fast[0] = 1'b1;
    repeat (F + 2) tick();
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    repeat (4) tick();
    bus.Fast[0] = 1'b0; repeat (8) tick();
    snap(1'b0);
    checks++;
    if (dch[0] !== W'(1)) begin errors++; $display("FAIL clr_count_ch0: got %0d expected 1", dch[0]); end
  endtask
  task automatic test_read_clear();
    clear();
    pulses(1, 7, 8, 8);
    snap(1'b1);
    checks++;
    if (dch[1] !== W'(7)) begin errors++; $display("FAIL readclr_ch1: got %0d expected 7", dch[1]); end
    tick();
    snap(1'b0);
    checks++;
    if (dch[1] !== '0) begin errors++; $display("FAIL readclr_after: got %0d expected 0", dch[1]); end
    checks++;
    if (bus.overflow !== 4'b0) begin errors++; $display("FAIL readclr_ovf: got %b expected 0000", bus.overflow); end
  endtask
  task automatic test_overflow();
    clear();
    pulses(3, 255, 5, 5);
    repeat (4) tick();
    snap(1'b0);
    checks++;
    if (dch[3] !== W'(255)) begin errors++; $display("FAIL ovf_full: got %0d expected 255", dch[3]); end
    checks++;
    if (bus.overflow !== 4'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0000", bus.overflow); end
    pulses(3, 1, 5, 5);
    repeat (4) tick();
    snap(1'b0);
    checks++;
    if (dch[3] !== '0) begin errors++; $display("FAIL ovf_wrap: got %0d expected 0", dch[3]); end
    checks++;
    if (bus.overflow !== 4'b1000) begin errors++; $display("FAIL ovf_flag: got %b expected 1000", bus.overflow); end
    snap(1'b1);
    checks++;
    if (bus.overflow !== 4'b1000) begin errors++; $display("FAIL ovf_readclr: got %b expected 1000", bus.overflow); end
    snap(1'b0);
    checks++;
    if (bus.overflow !== 4'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0000", bus.overflow); end
  endtask
  task automatic test_random();
    int rem [4];
    for (int c = 0; c < 4; c++) rem[c] = 1;
    repeat (1500) begin
      for (int c = 0; c < 4; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          bus.Fast[c] = ~bus.Fast[c];
          rem[c] = $urandom_range(1, 2 * F + 2);
        end
      end
      bus.snap_req = ($urandom_range(0, 5) == 0);
      bus.clr_req  = ($urandom_range(0, 39) == 0);
      tick();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (dch[c] !== m_ch[c]) begin errors++; $display("FAIL rand_ch%0d: got %0d expected %0d", c, dch[c], m_ch[c]); end
      end
      checks++;
      if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf: got %b expected %b", bus.overflow, m_ovf); end
      checks++;
      if (bus.snap_valid !== m_sv) begin errors++; $display("FAIL rand_valid: got %b expected %b", bus.snap_valid, m_sv); end
    end
    bus.snap_req = 1'b0; bus.clr_req = 1'b0; bus.Fast = '0;
    repeat (12) tick();
  endtask
  task automatic test_reset_mid();
    pulses(3, 2, 8, 8);
    snap(1'b0);
    bus.Fast[3] = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dch[c] !== '0) begin errors++; $display("FAIL midrst_ch%0d: got %0d expected 0", c, dch[c]); end
    end
    checks++;
    if (bus.overflow !== 4'b0 || bus.snap_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got ovf=%b valid=%b expected 0000/0", bus.overflow, bus.snap_valid);
    end
    rst = 1'b1;
    repeat (F + 6) tick();
    snap(1'b0);
    checks++;
    if (dch[3] !== W'(1)) begin errors++; $display("FAIL midrst_ch3: got %0d expected 1", dch[3]); end
    checks++;
    if (dch[3] !== m_ch[3]) begin errors++; $display("FAIL midrst_model: got %0d expected %0d", dch[3], m_ch[3]); end
    bus.Fast[3] = 1'b0; repeat (4) tick();
  endtask
  initial begin
    test_reset();
    test_pulse_train();
    test_glitch();
    test_latency();
    test_clr_count();
    test_read_clear();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/fast_pulse_counter.md
FAST_PULSE_COUNTER -- requirements
Module: fast_pulse_counter

Interface
REQ-001 The block SHALL have parameter FILT_LEN, default 4: consecutive clk cycles a synchronized input must hold a new level before that level is accepted (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 32: width of each channel counter.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port Fast  input  4  asynchronous pulse inputs, one per channel.
REQ-006 The block SHALL have port snap_req  input  1  single-cycle pulse requesting a snapshot of all live counters.
REQ-007 The block SHALL have port clr_req  input  1  single-cycle pulse clearing all live counters and overflow flags.
REQ-008 The block SHALL have ports channel0..channel3  output  CNT_W  snapshot counts for Fast[0]..Fast[3].
REQ-009 The block SHALL have port snap_valid  output  1  one-cycle strobe marking updated channel outputs.
REQ-010 The block SHALL have port overflow  output  4  sticky per-channel wrap flags, snapshotted with the counts.

Function
REQ-011 Each Fast bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL have a glitch filter holding a filtered level and a run counter.
REQ-013 The filter SHALL clear its run counter whenever the synchronized level equals the filtered level.
REQ-014 The filter SHALL update the filtered level when the synchronized level has differed from it for FILT_LEN consecutive cycles, then clear the run counter.
REQ-015 Pulses, high or low, shorter than FILT_LEN cycles at the synchronizer output SHALL be ignored.
REQ-016 A 0->1 transition of the filtered level SHALL increment that channel's live counter by exactly 1 on the next clk edge; falling transitions SHALL NOT count.
REQ-017 Latency SHALL be FILT_LEN+3 clk edges from the first edge sampling Fast high to the live counter update.
REQ-018 A live counter SHALL wrap from 2^CNT_W-1 to 0, and that wrap SHALL set the channel's sticky live overflow bit.
REQ-019 On snap_req, channel0..3 and overflow SHALL load the live values on the next edge, and snap_valid SHALL be 1 for exactly that following cycle.
REQ-020 A snapshot SHALL capture the live value before any increment occurring on the same edge; that increment SHALL still apply to the live counter.
REQ-021 On clr_req, all live counters and live overflow bits SHALL become 0; snapshot outputs SHALL be unaffected.
REQ-022 When clr_req and a counting edge coincide, the live counter SHALL become 1.
REQ-023 When snap_req and clr_req coincide, the snapshot SHALL capture pre-clear values (read-and-clear), then the clear SHALL apply.
REQ-024 Channel outputs SHALL hold between snapshots; the four channels SHALL be independent, with simultaneous edges all counted.
REQ-025 snap_req asserted on consecutive cycles SHALL produce a snapshot and a snap_valid strobe on every such cycle.

Reset
REQ-026 While rst=0, synchronizers, filtered levels, run counters, live counters, overflow bits, channel0..3, overflow and snap_valid SHALL all be 0.
REQ-027 Reset asserted mid-filter or mid-count SHALL discard the partial state; after release, an input already high SHALL count once, after FILT_LEN+3 cycles.

Verification
REQ-028 FILT_LEN=4: 10 pulses on Fast[0], each 8 high / 8 low cycles, then snap_req -> channel0=10, channel1..3=0, snap_valid one cycle.
REQ-029 FILT_LEN=4: Fast[2] pulses of 3 cycles, then a 1-cycle low dropout inside a 20-cycle high, then snap -> channel2 counts only the 20-cycle pulse (=1).
REQ-030 A single edge is timed: counter changes exactly FILT_LEN+3 edges after Fast rises; snap_req one edge earlier -> old value captured.
REQ-031 Live counter preloaded to 0xFFFFFFFF via 2^32-1 edges (or CNT_W=8 with 255 edges), plus one more edge, then snap -> channelN=0 and overflow[N]=1.
REQ-032 snap_req+clr_req together with channel1=7 -> channel1=7 in the snapshot; next snap -> channel1=0, overflow=0.
REQ-033 rst pulsed low during a count -> all outputs 0; Fast[3] held high through release -> next snap gives channel3=1.
